// File: rtl/lcd_write_engine_pkg.sv
// ---------------------------------------------------------------------------
// lcd_write_engine_pkg
//   Shared definitions for the LCD write engine: FSM state encoding, the
//   latched request record, HD44780 command constants, default timing
//   constants at 50 MHz and helpers for loading the delay counter.
//   No ports (package).
// ---------------------------------------------------------------------------
package lcd_write_engine_pkg;

   // Delay counter width, sized so the longest gap (82000 cycles) fits.
   localparam int unsigned DLY_W = 17;

   // HD44780 commands that need the long execution gap.
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // Default timing in 50 MHz clock cycles.
   localparam int unsigned DEF_SETUP_CYC      = 2;      // >= 40 ns
   localparam int unsigned DEF_PULSE_CYC      = 12;     // >= 230 ns
   localparam int unsigned DEF_HOLD_CYC       = 1;
   localparam int unsigned DEF_NIBBLE_GAP_CYC = 50;     // 1 us
   localparam int unsigned DEF_CMD_GAP_CYC    = 2000;   // 40 us
   localparam int unsigned DEF_LONG_GAP_CYC   = 82000;  // 1.64 ms

   typedef enum logic [3:0] {
      IDLE,
      SETUP_H,
      PULSE_H,
      HOLD_H,
      GAP_H,
      SETUP_L,
      PULSE_L,
      HOLD_L,
      GAP_L
   } lcd_state_t;

   // Request captured when the engine accepts iStart.
   typedef struct packed {
      logic [7:0] data;
      logic       rs;
      logic       nibble_only;
   } lcd_req_t;

   // Counter load value for a state lasting 'cyc' cycles. The counter
   // loads (count-1) on entry and the state ends when it reads zero,
   // so a duration of 0 degenerates to a single cycle.
   function automatic logic [DLY_W-1:0] cyc_to_load(input int unsigned cyc);
      if (cyc == 0) return '0;
      return DLY_W'(cyc - 1);
   endfunction

   // Clear and Home are slow commands; only a full command byte qualifies.
   function automatic logic needs_long_gap(input lcd_req_t req);
      return !req.nibble_only && !req.rs &&
             ((req.data == LCD_CMD_CLEAR) || (req.data == LCD_CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_write_engine_delay.sv
// ---------------------------------------------------------------------------
// lcd_delay_counter
//   Loadable down-counter that times each LCD sequencing state. It holds at
//   zero once expired; a load always takes priority over counting.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     load      in   load load_val this cycle
//     load_val  in   DLY_W-bit value to load (duration - 1)
//     zero      out  counter currently reads zero
// ---------------------------------------------------------------------------
module lcd_delay_counter
   import lcd_write_engine_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DLY_W-1:0] load_val,
   output logic             zero
);

   logic [DLY_W-1:0] count_q;

   // NOTE: sequential state is updated with non-blocking assignments so
   // every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - DLY_W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// ---------------------------------------------------------------------------
// lcd_write_engine
//   Executes one LCD write (full byte as two nibbles, or a single high
//   nibble) on the Spartan-3E character LCD 4-bit bus, generating HD44780
//   setup, enable pulse, hold and execution-gap timing in hardware.
//   Ports:
//     Clock        in   system clock, 50 MHz
//     Reset        in   asynchronous active-low reset
//     iStart       in   request strobe, sampled only while oReady=1
//     iData[7:0]   in   byte to write (nibble mode uses iData[7:4])
//     iRS          in   register select: 0 = command, 1 = data
//     iNibbleOnly  in   1 = send only iData[7:4]
//     oReady       out  engine idle; iStart is accepted this cycle
//     oDone        out  one-cycle pulse after the final gap completes
//     oLCD_E       out  LCD enable
//     oLCD_RS      out  LCD register select
//     oLCD_RW      out  LCD read/write, always 0 (write)
//     oLCD_D[3:0]  out  LCD data nibble (SF_D[11:8])
//   All outputs derive from registers only; there is no input-to-output
//   combinational path.
// ---------------------------------------------------------------------------
module lcd_write_engine
   import lcd_write_engine_pkg::*;
#(
   parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
   parameter int unsigned PULSE_CYC      = DEF_PULSE_CYC,
   parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
   parameter int unsigned NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
   parameter int unsigned CMD_GAP_CYC    = DEF_CMD_GAP_CYC,
   parameter int unsigned LONG_GAP_CYC   = DEF_LONG_GAP_CYC
)(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iStart,
   input  logic [7:0] iData,
   input  logic       iRS,
   input  logic       iNibbleOnly,
   output logic       oReady,
   output logic       oDone,
   output logic       oLCD_E,
   output logic       oLCD_RS,
   output logic       oLCD_RW,
   output logic [3:0] oLCD_D
);

   localparam logic [DLY_W-1:0] SETUP_LD      = cyc_to_load(SETUP_CYC);
   localparam logic [DLY_W-1:0] PULSE_LD      = cyc_to_load(PULSE_CYC);
   localparam logic [DLY_W-1:0] HOLD_LD       = cyc_to_load(HOLD_CYC);
   localparam logic [DLY_W-1:0] NIBBLE_GAP_LD = cyc_to_load(NIBBLE_GAP_CYC);
   localparam logic [DLY_W-1:0] CMD_GAP_LD    = cyc_to_load(CMD_GAP_CYC);
   localparam logic [DLY_W-1:0] LONG_GAP_LD   = cyc_to_load(LONG_GAP_CYC);

   lcd_state_t       state_q;
   lcd_state_t       state_d;
   lcd_req_t         req_q;
   logic             done_q;
   logic             cnt_load;
   logic [DLY_W-1:0] cnt_load_val;
   logic             cnt_zero;
   logic [DLY_W-1:0] final_gap_ld;

   lcd_delay_counter u_delay (
      .clk      (Clock),
      .rst_n    (Reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   // Final gap depends only on the latched request, which is stable for the
   // whole transfer, so it is valid whenever a gap state is entered.
   assign final_gap_ld = needs_long_gap(req_q) ? LONG_GAP_LD : CMD_GAP_LD;

   // -------------------------------------------------------------------
   // Next-state logic and delay-counter loading
   // -------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path
   // through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;

      case (state_q)
         IDLE:    if (iStart)   state_d = SETUP_H;
         SETUP_H: if (cnt_zero) state_d = PULSE_H;
         PULSE_H: if (cnt_zero) state_d = HOLD_H;
         HOLD_H:  if (cnt_zero) state_d = GAP_H;
         GAP_H:   if (cnt_zero) state_d = req_q.nibble_only ? IDLE : SETUP_L;
         SETUP_L: if (cnt_zero) state_d = PULSE_L;
         PULSE_L: if (cnt_zero) state_d = HOLD_L;
         HOLD_L:  if (cnt_zero) state_d = GAP_L;
         GAP_L:   if (cnt_zero) state_d = IDLE;
         default:               state_d = IDLE;
      endcase

      // Every state change reloads the counter with the new state's length.
      cnt_load = (state_d != state_q);
      case (state_d)
         SETUP_H, SETUP_L: cnt_load_val = SETUP_LD;
         PULSE_H, PULSE_L: cnt_load_val = PULSE_LD;
         HOLD_H,  HOLD_L:  cnt_load_val = HOLD_LD;
         GAP_H:            cnt_load_val = req_q.nibble_only ? final_gap_ld
                                                            : NIBBLE_GAP_LD;
         GAP_L:            cnt_load_val = final_gap_ld;
         default:          cnt_load_val = '0;
      endcase
   end

   // -------------------------------------------------------------------
   // State, request latch and done pulse
   // -------------------------------------------------------------------
   // NOTE: the latched request is cleared on reset so an aborted transfer
   // leaves nothing behind; with no storage array here, resetting every
   // register costs nothing and keeps simulation free of X.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // Capture only on acceptance; iStart while busy cannot disturb it.
         if ((state_q == IDLE) && iStart) begin
            req_q.data        <= iData;
            req_q.rs          <= iRS;
            req_q.nibble_only <= iNibbleOnly;
         end
         done_q <= ((state_q == GAP_H) || (state_q == GAP_L)) &&
                   (state_d == IDLE);
      end
   end

   // -------------------------------------------------------------------
   // LCD pin decode from state and latched request
   // -------------------------------------------------------------------
   always_comb begin
      oLCD_E  = 1'b0;
      oLCD_RS = 1'b0;
      oLCD_D  = 4'h0;
      case (state_q)
         SETUP_H, PULSE_H, HOLD_H, GAP_H: begin
            oLCD_D  = req_q.data[7:4];
            oLCD_RS = req_q.rs;
            oLCD_E  = (state_q == PULSE_H);
         end
         SETUP_L, PULSE_L, HOLD_L, GAP_L: begin
            oLCD_D  = req_q.data[3:0];
            oLCD_RS = req_q.rs;
            oLCD_E  = (state_q == PULSE_L);
         end
         default: ;
      endcase
   end

   assign oReady  = (state_q == IDLE);
   assign oDone   = done_q;
   assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_engine
//   Directed self-checking bench for lcd_write_engine with default timing.
//   Cycle n counts clock edges after the edge that accepts iStart; outputs
//   are sampled on the falling edge inside each cycle.
// ---------------------------------------------------------------------------
module tb_lcd_write_engine;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       iStart = 1'b0;
   logic [7:0] iData = 8'h00;
   logic       iRS = 1'b0;
   logic       iNibbleOnly = 1'b0;
   logic       oReady;
   logic       oDone;
   logic       oLCD_E;
   logic       oLCD_RS;
   logic       oLCD_RW;
   logic [3:0] oLCD_D;

   int n_checks = 0;
   int n_fail   = 0;

   // {ready, done, e, rs, rw, d[3:0]}
   logic [8:0] obs;
   assign obs = {oReady, oDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D};

   localparam logic [8:0] IDLE_VEC = 9'b1_0000_0000;

   always #10 Clock = ~Clock;

   lcd_write_engine dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iStart      (iStart),
      .iData       (iData),
      .iRS         (iRS),
      .iNibbleOnly (iNibbleOnly),
      .oReady      (oReady),
      .oDone       (oDone),
      .oLCD_E      (oLCD_E),
      .oLCD_RS     (oLCD_RS),
      .oLCD_RW     (oLCD_RW),
      .oLCD_D      (oLCD_D)
   );

   // Expected pin vector in cycle n of a transfer with default timing:
   // setup 2, pulse 12, hold 1, nibble gap 50, then the final gap.
   function automatic logic [8:0] exp_out(input int n, input logic [7:0] d,
                                          input logic rs, input logic nib,
                                          input int gap);
      int         busy;
      logic       e;
      logic [3:0] dd;
      busy = nib ? (15 + gap) : (80 + gap);
      if (n > busy) return {1'b1, (n == busy + 1), 7'b0};
      if (nib || (n <= 65)) begin
         dd = d[7:4];
         e  = (n >= 3) && (n <= 14);
      end else begin
         dd = d[3:0];
         e  = (n >= 68) && (n <= 79);
      end
      return {2'b00, e, rs, 1'b0, dd};
   endfunction

   // Present a request and let the accepting edge pass; the caller drops
   // iStart on the following falling edge (cycle 1).
   task automatic drive(input logic [7:0] d, input logic rs, input logic nib);
      @(negedge Clock);
      iData       = d;
      iRS         = rs;
      iNibbleOnly = nib;
      iStart      = 1'b1;
      @(posedge Clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clock);
      n_checks++;
      if (obs !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL reset_asserted: got %b expected %b", obs, IDLE_VEC);
      end
      Reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock);
         n_checks++;
         if (obs !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, IDLE_VEC);
         end
      end
   endtask

   task automatic test_full_byte();
      logic [8:0] exp;
      drive(8'h48, 1'b1, 1'b0);
      for (int n = 1; n <= 2082; n++) begin
         @(negedge Clock);
         iStart = 1'b0;
         exp = exp_out(n, 8'h48, 1'b1, 1'b0, 2000);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL full_byte cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
   endtask

   task automatic test_long_gap();
      logic [8:0] exp;
      drive(8'h01, 1'b0, 1'b0);
      for (int n = 1; n <= 82082; n++) begin
         @(negedge Clock);
         iStart = 1'b0;
         exp = exp_out(n, 8'h01, 1'b0, 1'b0, 82000);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL long_gap cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
   endtask

   task automatic test_nibble();
      logic [8:0] exp;
      int         pulses = 0;
      logic       e_prev = 1'b0;
      drive(8'h30, 1'b0, 1'b1);
      for (int n = 1; n <= 2017; n++) begin
         @(negedge Clock);
         iStart = 1'b0;
         if (oLCD_E && !e_prev) pulses++;
         e_prev = oLCD_E;
         exp = exp_out(n, 8'h30, 1'b0, 1'b1, 2000);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL nibble cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL nibble_pulses: got %0d expected 1", pulses);
      end
   endtask

   // iStart stays high with changing data while busy: the first transfer
   // must keep its own data and the second must start in the oDone cycle.
   task automatic test_back_to_back();
      logic [8:0] exp;
      int         pulses = 0;
      logic       e_prev = 1'b0;
      drive(8'h30, 1'b0, 1'b1);
      for (int n = 1; n <= 2032; n++) begin
         @(negedge Clock);
         if (n == 1) iData = 8'h50;
         if (n == 2017) iStart = 1'b0;
         if (n <= 2016) begin
            if (oLCD_E && !e_prev) pulses++;
            e_prev = oLCD_E;
            exp = exp_out(n, 8'h30, 1'b0, 1'b1, 2000);
         end else begin
            exp = exp_out(n - 2016, 8'h50, 1'b0, 1'b1, 2000);
         end
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL back_to_back_pulses: got %0d expected 1", pulses);
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [8:0] exp;
      // Abort whatever the previous scenario left running.
      @(negedge Clock);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;

      drive(8'h48, 1'b1, 1'b0);
      for (int n = 1; n <= 70; n++) begin
         @(negedge Clock);
         iStart = 1'b0;
         exp = exp_out(n, 8'h48, 1'b1, 1'b0, 2000);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL pre_abort cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
      // Cycle 70 is inside PULSE_L; reset between clock edges.
      #5 Reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL abort_immediate: got %b expected %b", obs, IDLE_VEC);
      end
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         n_checks++;
         if (obs !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL post_abort_idle cycle %0d: got %b expected %b", i, obs, IDLE_VEC);
         end
      end
      drive(8'h48, 1'b1, 1'b0);
      for (int n = 1; n <= 16; n++) begin
         @(negedge Clock);
         iStart = 1'b0;
         exp = exp_out(n, 8'h48, 1'b1, 1'b0, 2000);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL post_abort_restart cycle %0d: got %b expected %b", n, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_byte();
      test_long_gap();
      test_nibble();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
